// File: rtl/gauss_pkg.sv
// gauss_pkg: Q8.8 Gaussian taps, rounding constant and vertical-stage state type shared by the 5x5 filter stages.
package gauss_pkg;
   localparam logic [15:0] COEFF_0 = 16'd7;
   localparam logic [15:0] COEFF_1 = 16'd60;
   localparam logic [15:0] COEFF_2 = 16'd122;
   localparam logic [15:0] COEFF_3 = 16'd60;
   localparam logic [15:0] COEFF_4 = 16'd7;
   localparam int ROUND = 128;
   typedef enum logic [1:0] {PRIME, STREAM, FLUSH0, FLUSH1} vstate_t;
   function automatic int mirror_row(input int r, input int h);
      return r < 0 ? -r - 1 : r >= h ? 2 * h - 1 - r : r;
   endfunction
endpackage

// File: rtl/gauss_filter_5x1_if.sv
// gauss_filter_5x1_if: AXI-stream pixel channel with producer (master) and consumer (slave) views.
interface gauss_filter_5x1_if #(parameter int DATA_WIDTH = 8);
   logic [DATA_WIDTH-1:0] tdata;
   logic tvalid;
   logic tlast;
   logic tready;
   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/gauss_line_buffer.sv
// gauss_line_buffer: one-row simple dual-port RAM, read-first so a row can be read while its slot is overwritten.
module gauss_line_buffer #(
   parameter int DEPTH = 640,
   parameter int DATA_WIDTH = 8,
   parameter int AW = $clog2(DEPTH)
) (
   input logic clk,
   input logic we,
   input logic [AW-1:0] waddr,
   input logic [DATA_WIDTH-1:0] wdata,
   input logic re,
   input logic [AW-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end
endmodule

// File: rtl/gauss_filter_5x1.sv
// gauss_filter_5x1: vertical 5-tap Q8.8 Gaussian over four line buffers with mirrored borders and full backpressure.
module gauss_filter_5x1
   import gauss_pkg::*;
#(
   parameter int WIDTH = 640,
   parameter int HEIGHT = 512,
   parameter int DATA_WIDTH = 8,
   parameter int COEFF_WIDTH = 16,
   parameter int FRAC_WIDTH = 8
) (
   input logic clk,
   input logic rst_ni,
   gauss_filter_5x1_if.slave s_axis,
   gauss_filter_5x1_if.master m_axis,
   output logic frame_err_o
);
   localparam int CW = $clog2(WIDTH);
   localparam int RW = $clog2(HEIGHT);
   localparam int PW = DATA_WIDTH + COEFF_WIDTH;
   localparam int AW = PW + 3;
   localparam logic [CW-1:0] COL_MAX = CW'(WIDTH - 1);
   localparam logic [RW-1:0] ROW_MAX = RW'(HEIGHT - 1);
   localparam logic [COEFF_WIDTH-1:0] K [5] = '{COEFF_WIDTH'(COEFF_0), COEFF_WIDTH'(COEFF_1),
      COEFF_WIDTH'(COEFF_2), COEFF_WIDTH'(COEFF_3), COEFF_WIDTH'(COEFF_4)};

   logic [1:0] rst_q;
   logic rst_n;
   vstate_t state;
   logic [RW-1:0] row;
   logic [CW-1:0] col;
   logic streaming, accept, launch, col_end, row_end;
   logic en1, en2, en3, v1, v2, last1, last2;
   logic [2:0] sel_n [5];
   logic [2:0] sel1 [5];
   logic [DATA_WIDTH-1:0] rd [4];
   logic [DATA_WIDTH-1:0] tap [5];
   logic [DATA_WIDTH-1:0] live1, pix;
   logic [PW-1:0] prod2 [5];
   logic [AW-1:0] sum, rnd;
   int orow, m;

   always_ff @(posedge clk or negedge rst_ni)
      if (!rst_ni) rst_q <= '0;
      else rst_q <= {rst_q[0], 1'b1};
   assign rst_n = rst_q[1];

   // each stage advances whenever the one after it is empty or advancing
   assign en3 = !m_axis.tvalid || m_axis.tready;
   assign en2 = !v2 || en3;
   assign en1 = !v1 || en2;
   assign streaming = state == PRIME || state == STREAM;
   assign s_axis.tready = rst_n && streaming && en1;
   assign accept = s_axis.tvalid && s_axis.tready;
   assign col_end = col == COL_MAX;
   assign row_end = s_axis.tlast || col_end;
   assign launch = (state == STREAM && accept) || (!streaming && en1);

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= PRIME;
         row <= '0;
         col <= '0;
         frame_err_o <= 1'b0;
      end else begin
         frame_err_o <= accept && (s_axis.tlast != col_end);
         if (accept) begin
            col <= row_end ? '0 : col + CW'(1);
            if (row_end) begin
               row <= row == ROW_MAX ? '0 : row + RW'(1);
               if (state == PRIME && row == RW'(1)) state <= STREAM;
               if (state == STREAM && row == ROW_MAX) state <= FLUSH0;
            end
         end else if (launch) begin
            col <= col_end ? '0 : col + CW'(1);
            if (col_end) state <= state == FLUSH0 ? FLUSH1 : PRIME;
         end
      end

   for (genvar b = 0; b < 4; b++) begin : g_buf
      gauss_line_buffer #(.DEPTH(WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_buf (
         .clk(clk), .we(accept && row[1:0] == 2'(b)), .waddr(col), .wdata(s_axis.tdata),
         .re(launch), .raddr(col), .rdata(rd[b]));
   end

   // tap source: buffer index row mod 4, or 4 for the live beat
   always_comb begin
      orow = state == FLUSH0 ? HEIGHT - 2 : state == FLUSH1 ? HEIGHT - 1 : int'(row) - 2;
      m = 0;
      for (int t = 0; t < 5; t++) begin
         m = mirror_row(orow - 2 + t, HEIGHT);
         sel_n[t] = (state == STREAM && m == int'(row)) ? 3'd4 : {1'b0, m[1:0]};
      end
   end

   always_comb
      for (int t = 0; t < 5; t++) tap[t] = sel1[t][2] ? live1 : rd[sel1[t][1:0]];

   always_comb begin
      sum = '0;
      for (int t = 0; t < 5; t++) sum = sum + AW'(prod2[t]);
      rnd = (sum + AW'(ROUND)) >> FRAC_WIDTH;
      pix = |rnd[AW-1:DATA_WIDTH] ? '1 : rnd[DATA_WIDTH-1:0];
   end

   always_ff @(posedge clk) begin
      if (launch) begin
         sel1 <= sel_n;
         live1 <= s_axis.tdata;
         last1 <= col_end;
      end
      if (en2 && v1) begin
         for (int t = 0; t < 5; t++) prod2[t] <= PW'(tap[t]) * PW'(K[t]);
         last2 <= last1;
      end
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
         m_axis.tvalid <= 1'b0;
         m_axis.tdata <= '0;
         m_axis.tlast <= 1'b0;
      end else begin
         if (en1) v1 <= launch;
         if (en2) v2 <= v1;
         if (en3) begin
            m_axis.tvalid <= v2;
            if (v2) begin
               m_axis.tdata <= pix;
               m_axis.tlast <= last2;
            end
         end
      end
endmodule

// File: tb/tb_gauss_filter_5x1.sv
// tb_gauss_filter_5x1: directed frames with hand-derived outputs, plus random frames against a column-filter model.
module tb_gauss_filter_5x1;
   localparam int W = 16;
   localparam int H = 8;

   logic clk = 1'b0;
   logic rst_ni = 1'b1;
   logic frame_err;
   gauss_filter_5x1_if #(.DATA_WIDTH(8)) s_if ();
   gauss_filter_5x1_if #(.DATA_WIDTH(8)) m_if ();

   gauss_filter_5x1 #(.WIDTH(W), .HEIGHT(H), .DATA_WIDTH(8), .COEFF_WIDTH(16), .FRAC_WIDTH(8)) dut (
      .clk(clk), .rst_ni(rst_ni), .s_axis(s_if), .m_axis(m_if), .frame_err_o(frame_err));

   always #5 clk = ~clk;

   int n_chk = 0, n_pass = 0;
   int cyc = 0, n_in = 0, t_in = -1, t_out = -1, err_cnt = 0;
   bit rnd_rdy = 1'b0;
   int q_d[$];
   int q_l[$];
   int img [H][W];
   int exp_img [H][W];

   task automatic check(input string tag, input int got, input int want);
      n_chk++;
      if (got == want) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, want);
   endtask

   always @(negedge clk) begin
      cyc++;
      if (s_if.tvalid && s_if.tready) begin
         if (n_in == 2 * W && t_in < 0) t_in = cyc;
         n_in++;
      end
      if (m_if.tvalid && t_out < 0) t_out = cyc;
      if (m_if.tvalid && m_if.tready) begin
         q_d.push_back(int'(m_if.tdata));
         q_l.push_back(int'(m_if.tlast));
      end
      if (frame_err) err_cnt++;
   end

   initial forever begin
      @(posedge clk);
      #1 m_if.tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   function automatic int gold(input int o, input int x);
      int k[5] = '{7, 60, 122, 60, 7};
      int acc = 0;
      for (int t = 0; t < 5; t++) begin
         int r = o - 2 + t;
         if (r < 0) r = -r - 1;
         if (r > H - 1) r = 2 * H - 1 - r;
         acc += k[t] * img[r][x];
      end
      acc = (acc + 128) >> 8;
      return acc > 255 ? 255 : acc;
   endfunction

   task automatic send_beat(input int d, input bit l);
      int g = 0;
      s_if.tdata = 8'(d);
      s_if.tlast = l;
      s_if.tvalid = 1'b1;
      @(negedge clk);
      while (!s_if.tready && g < 2000) begin
         g++;
         @(negedge clk);
      end
      if (g >= 2000) check("in_timeout", g, 0);
      @(posedge clk);
      #1 s_if.tvalid = 1'b0;
   endtask

   task automatic start_frame();
      q_d.delete();
      q_l.delete();
      n_in = 0;
      t_in = -1;
      t_out = -1;
      err_cnt = 0;
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame();
      for (int r = 0; r < H; r++)
         for (int x = 0; x < W; x++) send_beat(img[r][x], x == W - 1);
      @(negedge clk);
      check("flush_rdy", int'(s_if.tready), 0);
   endtask

   task automatic expect_frame(input string tag);
      int g = 0;
      while (q_d.size() < H * W && g < 5000) begin
         g++;
         @(negedge clk);
      end
      repeat (10) @(negedge clk);
      check({tag, "_count"}, q_d.size(), H * W);
      for (int i = 0; i < q_d.size() && i < H * W; i++) begin
         check($sformatf("%s_px%0d", tag, i), q_d[i], exp_img[i / W][i % W]);
         check($sformatf("%s_last%0d", tag, i), q_l[i], int'(i % W == W - 1));
      end
      check({tag, "_err"}, err_cnt, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_tvalid"}, int'(m_if.tvalid), 0);
      check({tag, "_tdata"}, int'(m_if.tdata), 0);
      check({tag, "_tlast"}, int'(m_if.tlast), 0);
      check({tag, "_err"}, int'(frame_err), 0);
      check({tag, "_s_ready"}, int'(s_if.tready), 0);
   endtask

   initial begin
      s_if.tvalid = 1'b0;
      s_if.tdata = '0;
      s_if.tlast = 1'b0;
      m_if.tready = 1'b1;
      #3 rst_ni = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_outputs("rst");
      rst_ni = 1'b1;
      repeat (4) @(negedge clk);

      foreach (img[r, x]) begin
         img[r][x] = 100;
         exp_img[r][x] = 100;
      end
      start_frame();
      send_frame();
      expect_frame("const");
      check("latency", t_out - t_in, 3);

      foreach (img[r, x]) begin
         img[r][x] = 0;
         exp_img[r][x] = 0;
      end
      img[5][10] = 255;
      exp_img[3][10] = 7;
      exp_img[4][10] = 60;
      exp_img[5][10] = 122;
      exp_img[6][10] = 60;
      exp_img[7][10] = 7;
      start_frame();
      send_frame();
      expect_frame("impulse");

      foreach (img[r, x]) begin
         img[r][x] = r == 0 ? 200 : 0;
         exp_img[r][x] = r == 0 ? 142 : r == 1 ? 52 : r == 2 ? 5 : 0;
      end
      start_frame();
      send_frame();
      expect_frame("top");

      foreach (img[r, x]) begin
         img[r][x] = r == 7 ? 200 : 0;
         exp_img[r][x] = r == 7 ? 142 : r == 6 ? 52 : r == 5 ? 5 : 0;
      end
      start_frame();
      send_frame();
      expect_frame("bottom");

      foreach (img[r, x]) img[r][x] = int'($urandom_range(0, 255));
      foreach (exp_img[r, x]) exp_img[r][x] = gold(r, x);
      rnd_rdy = 1'b1;
      start_frame();
      send_frame();
      expect_frame("stall");
      rnd_rdy = 1'b0;

      start_frame();
      for (int r = 0; r < 3; r++)
         for (int x = 0; x < W; x++) send_beat(int'($urandom_range(0, 255)), x == W - 1);
      for (int x = 0; x < 10; x++) send_beat(int'($urandom_range(0, 255)), x == 9);
      for (int x = 0; x < 5; x++) send_beat(int'($urandom_range(0, 255)), 1'b0);
      repeat (3) @(negedge clk);
      check("early_tlast_pulse", err_cnt, 1);
      #2 rst_ni = 1'b0;
      #1 check_reset_outputs("mid_rst");
      repeat (3) @(negedge clk);
      check_reset_outputs("mid_rst_hold");
      rst_ni = 1'b1;
      repeat (4) @(negedge clk);

      foreach (img[r, x]) img[r][x] = int'($urandom_range(0, 255));
      foreach (exp_img[r, x]) exp_img[r][x] = gold(r, x);
      start_frame();
      send_frame();
      expect_frame("clean");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
